alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal range 2..64.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning a, b and f hold a valid request.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a request this cycle.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each, the operands.
REQ-007 The block SHALL have port f, input, 3 bits, the operation select.
REQ-008 The block SHALL have port y, output, WIDTH bits, the registered result.
REQ-009 The block SHALL have ports cout, overflow and zero, output, 1 bit each, the registered flags.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning y and the flags are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning the consumer takes the result.

Function
REQ-012 A request SHALL be accepted on a rising edge where in_valid && in_ready; a, b and f SHALL be captured then, and later input changes SHALL have no effect.
REQ-013 Decode of f SHALL be as follows. bb = f[2] ? ~b : b.
- 000: a&b
- 001: a|b
- 010: a+b
- 100: a&~b
- 101: a|~b
- 110: a-b
- 111: SLT
- 011: MUL
REQ-014 For f[1:0]=10, the sum SHALL be a+bb+f[2] computed at WIDTH+1 bits; cout SHALL be bit WIDTH of that sum.
REQ-015 For f[1:0]=10, overflow SHALL be true signed overflow: set when a and bb have equal sign bits and the sum sign differs.
REQ-016 SLT (111) SHALL compute a-b and set y = {WIDTH-1 zeros, sign(a-b) XOR overflow}, a signed comparison; cout and overflow SHALL report the subtraction.
REQ-017 MUL (011) SHALL produce y = low WIDTH bits of a*b (unsigned) by iterative shift-add, one multiplier bit per cycle; cout=0 and overflow=0.
REQ-018 Logic ops SHALL produce cout=0 and overflow=0.
REQ-019 For every operation, zero SHALL be 1 when y == 0, else 0.
REQ-020 The state machine SHALL have three states: IDLE, MUL, HOLD.
REQ-021 IDLE transitions on accept: to HOLD for a non-MUL op, with y and the flags loaded at the accept edge; to MUL for MUL, with the counter cleared and the partial product cleared.
REQ-022 In MUL, each edge SHALL process one multiplier bit and increment the counter; the edge processing bit WIDTH-1 SHALL load y and the flags and go to HOLD.
REQ-023 HOLD on an edge with out_ready=1 and no new accept SHALL go to IDLE.
REQ-024 HOLD on an edge with out_ready=1 and in_valid=1 SHALL consume the current result and accept the new request in the same edge, following the IDLE accept rules (back-to-back).
REQ-025 HOLD with out_ready=0 SHALL keep y, the flags and out_valid=1 unchanged.
REQ-026 in_ready SHALL be 1 in IDLE, SHALL equal out_ready in HOLD, and SHALL be 0 in MUL.
REQ-027 out_valid SHALL be 1 exactly in HOLD.
REQ-028 Latency SHALL be as follows:
- Non-MUL op: out_valid rises at the accept edge (1 cycle).
- MUL: out_valid rises WIDTH edges after the accept edge.
REQ-029 Sustained throughput SHALL be one non-MUL result per cycle while out_ready=1.
REQ-030 in_valid in MUL SHALL be ignored; the request is not accepted and the upstream must hold it.
REQ-031 All arithmetic SHALL wrap modulo 2^WIDTH; no exceptions or stalls arise from overflow.

Reset
REQ-032 While reset_n=0, state SHALL be IDLE and the following SHALL be 0: y, cout, overflow, out_valid, the counter and the partial product.
REQ-033 While reset_n=0, zero SHALL be 1 and in_ready SHALL be 0.
REQ-034 Reset asserted mid-MUL or in HOLD SHALL abort immediately and discard the pending result.
REQ-035 After reset_n deasserts, in_ready SHALL be 1 from the first cycle.

Verification
REQ-036 Scenario 1 (WIDTH=32): ADD a=0x7FFFFFFF, b=1, out_ready=1 -> next cycle out_valid=1, y=0x80000000, overflow=1, cout=0, zero=0.
REQ-037 Scenario 2 (WIDTH=32): SUB a=5, b=5 -> y=0, zero=1, cout=1, overflow=0; SLT a=0xFFFFFFFF, b=1 -> y=1.
REQ-038 Scenario 3 (WIDTH=8): MUL a=0x0F, b=0x11 -> in_ready=0 for 8 cycles, then out_valid=1 with y=0xFF.
REQ-039 Scenario 4: out_ready=0 with result 0x1234 held and a/b changed for 5 cycles -> y stays 0x1234 and in_ready=0; then out_ready=1 and in_valid=1 -> next result accepted in the same edge.
REQ-040 Scenario 5: reset_n pulsed low for 1 ns during MUL cycle 3 -> all outputs per REQ-032/REQ-033 without waiting for a clock edge; the next MUL request runs a full WIDTH cycles and gives the correct product.
REQ-041 Scenario 6: four back-to-back ops AND, OR, a&~b, a|~b with a=0xF0F0F0F0, b=0xFF00FF00 and out_ready=1 -> four consecutive valid results 0xF000F000, 0xFFF0FFF0, 0x00F000F0, 0xF0FFF0FF.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/add/sub/slt and an iterative shift-add multiply,
// with a valid/ready handshake on both sides and a registered result.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       f,
   output logic [WIDTH-1:0] y,
   output logic             cout,
   output logic             overflow,
   output logic             zero,
   output logic             out_valid,
   input  logic             out_ready
);

   // state  | meaning
   // S_IDLE | no result pending, ready for a request
   // S_MUL  | shift-add multiply in progress, one multiplier bit per edge
   // S_HOLD | result valid on y/flags, waiting for out_ready

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [WIDTH-1:0] r_y;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_prod;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH-1:0] w_bb;
   logic [WIDTH:0]   w_sum;
   logic             w_add_ovf;
   logic [WIDTH-1:0] w_alu_y;
   logic             w_alu_cout;
   logic             w_alu_ovf;
   logic             w_is_mul;
   logic [WIDTH-1:0] w_prod_nxt;
   logic             w_mul_done;
   logic             w_accept;
   logic             w_load_alu;
   logic             w_load_mul;
   logic             w_start_mul;

   // Add/sub share one adder; f[2] inverts b and supplies the carry-in.
   always_comb begin
      w_bb      = f[2] ? ~b : b;
      w_sum     = {1'b0, a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, f[2]};
      w_add_ovf = (a[WIDTH-1] == w_bb[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      w_is_mul  = (f == 3'b011);
   end

   always_comb begin
      w_alu_y    = '0;
      w_alu_cout = 1'b0;
      w_alu_ovf  = 1'b0;
      case (f[1:0])
         2'b00: w_alu_y = a & w_bb;
         2'b01: w_alu_y = a | w_bb;
         2'b10: begin
            w_alu_y    = w_sum[WIDTH-1:0];
            w_alu_cout = w_sum[WIDTH];
            w_alu_ovf  = w_add_ovf;
         end
         default: begin
            if (f[2]) begin
               w_alu_y    = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_add_ovf};
               w_alu_cout = w_sum[WIDTH];
               w_alu_ovf  = w_add_ovf;
            end
         end
      endcase
   end

   always_comb begin
      w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});
      w_mul_done = (r_cnt == CNT_LAST);
   end

   // Reset gates in_ready so nothing is accepted while the block is held in reset.
   assign in_ready  = reset_n && ((r_state == S_IDLE) || ((r_state == S_HOLD) && out_ready));
   assign w_accept  = in_valid && in_ready;
   assign out_valid = (r_state == S_HOLD);
   assign y         = r_y;
   assign cout      = r_cout;
   assign overflow  = r_ovf;
   assign zero      = r_zero;

   always_comb begin
      w_state_nxt = r_state;
      w_load_alu  = 1'b0;
      w_load_mul  = 1'b0;
      w_start_mul = 1'b0;
      case (r_state)
         S_IDLE, S_HOLD: begin
            if (w_accept) begin
               if (w_is_mul) begin
                  w_state_nxt = S_MUL;
                  w_start_mul = 1'b1;
               end else begin
                  w_state_nxt = S_HOLD;
                  w_load_alu  = 1'b1;
               end
            end else if ((r_state == S_HOLD) && out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_MUL: begin
            if (w_mul_done) begin
               w_state_nxt = S_HOLD;
               w_load_mul  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_y      <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_zero   <= 1'b1;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_cnt    <= '0;
      end else begin
         if (w_load_alu) begin
            r_y    <= w_alu_y;
            r_cout <= w_alu_cout;
            r_ovf  <= w_alu_ovf;
            r_zero <= (w_alu_y == '0);
         end else if (w_load_mul) begin
            r_y    <= w_prod_nxt;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= (w_prod_nxt == '0);
         end
         if (w_start_mul) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_prod   <= '0;
            r_cnt    <= '0;
         end else if (r_state == S_MUL) begin
            r_prod   <= w_prod_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit instance for single-cycle ops and handshake,
// an 8-bit instance for multiply latency and reset abort.
module tb_alu_seq;

   logic        clk;
   logic        reset_n;

   logic        in_valid32, in_ready32, out_valid32, out_ready32;
   logic [31:0] a32, b32, y32;
   logic [2:0]  f32;
   logic        cout32, ovf32, zero32;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  a8, b8, y8;
   logic [2:0]  f8;
   logic        cout8, ovf8, zero8;

   int n_checks = 0;
   int n_errors = 0;

   alu_seq #(.WIDTH(32)) u_dut32 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid32), .in_ready(in_ready32),
      .a(a32), .b(b32), .f(f32), .y(y32), .cout(cout32), .overflow(ovf32),
      .zero(zero32), .out_valid(out_valid32), .out_ready(out_ready32)
   );

   alu_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .f(f8), .y(y8), .cout(cout8), .overflow(ovf8),
      .zero(zero8), .out_valid(out_valid8), .out_ready(out_ready8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic        cout;
      logic        ovf;
      logic        zero;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one 8-bit multiply from acceptance to result, checking in_ready stays low.
   task automatic run_mul8(input string name, input logic [7:0] ma, input logic [7:0] mb,
                           input logic [7:0] exp_y);
      int n;
      in_valid8 = 1'b1; a8 = ma; b8 = mb; f8 = 3'b011; out_ready8 = 1'b0;
      step();
      in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
      n = 0;
      while (!out_valid8 && n < 20) begin
         chk({name, "_in_ready_busy"}, in_ready8, 0);
         step();
         n++;
      end
      chk({name, "_latency"}, n, 8);
      chk({name, "_y"}, y8, exp_y);
      chk({name, "_cout"}, cout8, 0);
      chk({name, "_ovf"}, ovf8, 0);
      chk({name, "_zero"}, zero8, (exp_y == 8'h00));
      out_ready8 = 1'b1;
      step();
      chk({name, "_drained"}, out_valid8, 0);
      out_ready8 = 1'b0;
   endtask

   initial begin
      vecs.push_back('{"add_ovf",   3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{"sub_eq",    3'b110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{"slt_neg",   3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{"and",       3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"or",        3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"andn",      3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"orn",       3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF0FF_F0FF, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"add_wrap",  3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1});
      vecs.push_back('{"sub_borrow",3'b110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{"sub_ovf",   3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{"slt_false", 3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1});
      vecs.push_back('{"slt_min",   3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b1, 1'b0});
      vecs.push_back('{"and_zero",  3'b000, 32'h0000_000F, 32'h0000_00F0, 32'h0000_0000, 1'b0, 1'b0, 1'b1});

      reset_n = 1'b0;
      in_valid32 = 1'b0; a32 = '0; b32 = '0; f32 = '0; out_ready32 = 1'b0;
      in_valid8  = 1'b0; a8  = '0; b8  = '0; f8  = '0; out_ready8  = 1'b0;
      #12;
      chk("rst_y", y32, 0);
      chk("rst_zero", zero32, 1);
      chk("rst_cout", cout32, 0);
      chk("rst_ovf", ovf32, 0);
      chk("rst_out_valid", out_valid32, 0);
      chk("rst_in_ready", in_ready32, 0);
      reset_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready32, 1);
      chk("post_rst_in_ready8", in_ready8, 1);
      step();

      // Back-to-back table: one result per edge with out_ready held high.
      out_ready32 = 1'b1;
      foreach (vecs[i]) begin
         in_valid32 = 1'b1; a32 = vecs[i].a; b32 = vecs[i].b; f32 = vecs[i].f;
         #1;
         chk({vecs[i].name, "_in_ready"}, in_ready32, 1);
         step();
         chk({vecs[i].name, "_valid"}, out_valid32, 1);
         chk({vecs[i].name, "_y"}, y32, vecs[i].y);
         chk({vecs[i].name, "_cout"}, cout32, vecs[i].cout);
         chk({vecs[i].name, "_ovf"}, ovf32, vecs[i].ovf);
         chk({vecs[i].name, "_zero"}, zero32, vecs[i].zero);
      end
      in_valid32 = 1'b0;
      step();
      chk("table_drain", out_valid32, 0);

      // Hold with out_ready low, then back-to-back consume + accept.
      in_valid32 = 1'b1; a32 = 32'h1000; b32 = 32'h0234; f32 = 3'b010; out_ready32 = 1'b0;
      step();
      chk("hold_first_y", y32, 32'h1234);
      for (int k = 0; k < 5; k++) begin
         a32 = 32'h5555_0000 + k; b32 = 32'h0000_1111 * (k + 1); f32 = 3'b001;
         #1;
         chk("hold_in_ready", in_ready32, 0);
         step();
         chk("hold_y", y32, 32'h1234);
         chk("hold_valid", out_valid32, 1);
      end
      a32 = 32'h1; b32 = 32'h2; f32 = 3'b010; out_ready32 = 1'b1;
      #1;
      chk("b2b_in_ready", in_ready32, 1);
      step();
      chk("b2b_valid", out_valid32, 1);
      chk("b2b_y", y32, 32'h3);
      in_valid32 = 1'b0;
      step();
      chk("b2b_drain", out_valid32, 0);

      // 8-bit multiply latency and wraparound.
      run_mul8("mul_0f_11", 8'h0F, 8'h11, 8'hFF);
      run_mul8("mul_ff_ff", 8'hFF, 8'hFF, 8'h01);
      run_mul8("mul_zero", 8'h00, 8'h37, 8'h00);

      // Request presented during MUL must wait and be taken once HOLD drains.
      in_valid8 = 1'b1; a8 = 8'h03; b8 = 8'h05; f8 = 3'b011; out_ready8 = 1'b0;
      step();
      a8 = 8'h10; b8 = 8'h22; f8 = 3'b010;
      for (int k = 0; k < 8; k++) step();
      chk("mul_ignore_y", y8, 8'h0F);
      chk("mul_ignore_valid", out_valid8, 1);
      out_ready8 = 1'b1;
      step();
      chk("mul_then_add_y", y8, 8'h32);
      in_valid8 = 1'b0;
      step();
      chk("mul_then_add_drain", out_valid8, 0);
      out_ready8 = 1'b0;

      // Reset pulse during MUL cycle 3 aborts immediately.
      in_valid8 = 1'b1; a8 = 8'h0F; b8 = 8'h11; f8 = 3'b011;
      step();
      in_valid8 = 1'b0;
      step(); step();
      #2;
      reset_n = 1'b0;
      #1;
      chk("abort_y", y8, 0);
      chk("abort_zero", zero8, 1);
      chk("abort_cout", cout8, 0);
      chk("abort_ovf", ovf8, 0);
      chk("abort_out_valid", out_valid8, 0);
      chk("abort_in_ready", in_ready8, 0);
      reset_n = 1'b1;
      #1;
      chk("abort_release_in_ready", in_ready8, 1);
      step();
      run_mul8("mul_after_abort", 8'h0D, 8'h0B, 8'h8F);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
